// File: rtl/telemetria_pkg.sv
// Shared constants, FSM encoding and nibble-to-ASCII helper for the
// hexadecimal telemetry sender.
package telemetria_pkg;

    localparam logic [7:0] ASC_ZERO      = 8'h30;
    localparam logic [7:0] ASC_A         = 8'h41;
    localparam logic [7:0] ASC_ASTERISCO = 8'h2A;
    localparam logic [7:0] SEP_PADRAO    = 8'h2C;
    localparam logic [7:0] TERM_PADRAO   = 8'h23;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CARREGA = 3'd1,
        ENVIA   = 3'd2,
        ESPERA  = 3'd3,
        PROXIMO = 3'd4,
        FIM     = 3'd5
    } estado_t;

    typedef enum logic [2:0] {
        S_DIGITO     = 3'd0,
        S_SEPARADOR  = 3'd1,
        S_ASTERISCO  = 3'd2,
        S_CHK_ALTO   = 3'd3,
        S_CHK_BAIXO  = 3'd4,
        S_TERMINADOR = 3'd5
    } slot_t;

    function automatic logic [7:0] nibble_para_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return ASC_ZERO + {4'h0, n};
        else
            return ASC_A + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/telemetria_ascii_n_seletor.sv
// Combinational character selector: picks the ASCII byte for the
// current slot (hex digit, separator, checksum or terminator).
module seletor_caractere
    import telemetria_pkg::*;
#(
    parameter int         N_CH = 3,
    parameter int         W    = 12,
    parameter int         ND   = 3,
    parameter logic [7:0] SEP  = SEP_PADRAO,
    parameter logic [7:0] TERM = TERM_PADRAO
) (
    input  logic [N_CH*W-1:0] snapshot,
    input  logic [3:0]        canal,
    input  logic [2:0]        digito,
    input  slot_t             slot,
    input  logic [7:0]        soma,
    output logic [7:0]        caractere
);

    logic [4*ND-1:0] palavra;
    logic [3:0]      nibble;

    always_comb begin
        palavra        = '0;
        palavra[W-1:0] = snapshot[canal*W +: W];
        // digit 0 is the most significant nibble of the zero-padded word
        nibble         = palavra[(ND-1-int'(digito))*4 +: 4];
    end

    always_comb begin
        caractere = TERM;
        unique case (slot)
            S_DIGITO:     caractere = nibble_para_ascii(nibble);
            S_SEPARADOR:  caractere = SEP;
            S_ASTERISCO:  caractere = ASC_ASTERISCO;
            S_CHK_ALTO:   caractere = nibble_para_ascii(soma[7:4]);
            S_CHK_BAIXO:  caractere = nibble_para_ascii(soma[3:0]);
            S_TERMINADOR: caractere = TERM;
            default:      caractere = TERM;
        endcase
    end

endmodule

// File: rtl/telemetria_ascii_n.sv
// Parametrised hex-ASCII telemetry sender driving tx_serial_8N1.
// Optional XOR checksum before the terminator: TELEMETRIA_CHECKSUM_EN.
module telemetria_ascii_n
    import telemetria_pkg::*;
#(
    parameter int         N_CH = 3,
    parameter int         W    = 12,
    parameter logic [7:0] SEP  = SEP_PADRAO,
    parameter logic [7:0] TERM = TERM_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [N_CH*W-1:0] dados,
    input  logic              pronto_tx,
    output logic              partida_tx,
    output logic [7:0]        caractere,
    output logic              ocupado,
    output logic              fim_mensagem,
    output logic [2:0]        db_estado
);

    localparam int         ND     = (W + 3) / 4;
    localparam logic [2:0] ND_ULT = 3'(ND - 1);
    localparam logic [3:0] CH_ULT = 4'(N_CH - 1);

    estado_t           estado, prox;
    slot_t             slot;
    logic [N_CH*W-1:0] snapshot;
    logic [3:0]        canal;
    logic [2:0]        digito;
    logic [7:0]        soma;
    logic [7:0]        car_sel;

`ifndef TELEMETRIA_CHECKSUM_EN
    assign soma = 8'h00;
`endif

    seletor_caractere #(
        .N_CH (N_CH),
        .W    (W),
        .ND   (ND),
        .SEP  (SEP),
        .TERM (TERM)
    ) u_seletor (
        .snapshot  (snapshot),
        .canal     (canal),
        .digito    (digito),
        .slot      (slot),
        .soma      (soma),
        .caractere (car_sel)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= IDLE;
            snapshot  <= '0;
            canal     <= '0;
            digito    <= '0;
            slot      <= S_DIGITO;
            caractere <= 8'h00;
`ifdef TELEMETRIA_CHECKSUM_EN
            soma      <= 8'h00;
`endif
        end else begin
            estado <= prox;
            unique case (estado)
                IDLE: if (iniciar) begin
                    snapshot <= dados;
                    canal    <= '0;
                    digito   <= '0;
                    slot     <= S_DIGITO;
`ifdef TELEMETRIA_CHECKSUM_EN
                    soma     <= 8'h00;
`endif
                end
                CARREGA: caractere <= car_sel;
                PROXIMO: begin
`ifdef TELEMETRIA_CHECKSUM_EN
                    // only text before '*' enters the checksum
                    if (slot == S_DIGITO || slot == S_SEPARADOR)
                        soma <= soma ^ caractere;
`endif
                    unique case (slot)
                        S_DIGITO: begin
                            if (digito == ND_ULT) begin
                                digito <= '0;
                                if (canal != CH_ULT)
                                    slot <= S_SEPARADOR;
                                else
`ifdef TELEMETRIA_CHECKSUM_EN
                                    slot <= S_ASTERISCO;
`else
                                    slot <= S_TERMINADOR;
`endif
                            end else begin
                                digito <= digito + 3'd1;
                            end
                        end
                        S_SEPARADOR: begin
                            canal <= canal + 4'd1;
                            slot  <= S_DIGITO;
                        end
                        S_ASTERISCO: slot <= S_CHK_ALTO;
                        S_CHK_ALTO:  slot <= S_CHK_BAIXO;
                        default:     slot <= S_TERMINADOR;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        prox         = estado;
        partida_tx   = 1'b0;
        ocupado      = 1'b0;
        fim_mensagem = 1'b0;
        unique case (estado)
            IDLE: if (iniciar) prox = CARREGA;
            CARREGA: begin
                ocupado = 1'b1;
                prox    = ENVIA;
            end
            ENVIA: begin
                ocupado    = 1'b1;
                partida_tx = 1'b1;
                prox       = ESPERA;
            end
            ESPERA: begin
                ocupado = 1'b1;
                if (pronto_tx)
                    prox = (slot == S_TERMINADOR) ? FIM : PROXIMO;
            end
            PROXIMO: begin
                ocupado = 1'b1;
                prox    = CARREGA;
            end
            FIM: begin
                fim_mensagem = 1'b1;
                prox         = IDLE;
            end
            default: prox = IDLE;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_telemetria_ascii_n.sv
// Directed bench: three instances (3x12, 1x10, 1x5) with a responder
// that answers each partida_tx with pronto_tx ten cycles later.
module tb_telemetria_ascii_n;

`ifdef TELEMETRIA_CHECKSUM_EN
    localparam string EXP_A = "1A3,0FF,ABC*33#";
    localparam string EXP_B = "3FF*33#";
    localparam string EXP_C = "1F*77#";
`else
    localparam string EXP_A = "1A3,0FF,ABC#";
    localparam string EXP_B = "3FF#";
    localparam string EXP_C = "1F#";
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        ini_a, pronto_a, part_a, ocup_a, fim_a;
    logic [35:0] dados_a;
    logic [7:0]  car_a;
    logic [2:0]  est_a;

    logic        ini_b, pronto_b, part_b, ocup_b, fim_b;
    logic [9:0]  dados_b;
    logic [7:0]  car_b;
    logic [2:0]  est_b;

    logic        ini_c, pronto_c, part_c, ocup_c, fim_c;
    logic [4:0]  dados_c;
    logic [7:0]  car_c;
    logic [2:0]  est_c;

    int checks = 0;
    int errors = 0;

    telemetria_ascii_n #(.N_CH(3), .W(12)) dut_a (
        .clock(clock), .reset(reset), .iniciar(ini_a), .dados(dados_a),
        .pronto_tx(pronto_a), .partida_tx(part_a), .caractere(car_a),
        .ocupado(ocup_a), .fim_mensagem(fim_a), .db_estado(est_a)
    );

    telemetria_ascii_n #(.N_CH(1), .W(10)) dut_b (
        .clock(clock), .reset(reset), .iniciar(ini_b), .dados(dados_b),
        .pronto_tx(pronto_b), .partida_tx(part_b), .caractere(car_b),
        .ocupado(ocup_b), .fim_mensagem(fim_b), .db_estado(est_b)
    );

    telemetria_ascii_n #(.N_CH(1), .W(5)) dut_c (
        .clock(clock), .reset(reset), .iniciar(ini_c), .dados(dados_c),
        .pronto_tx(pronto_c), .partida_tx(part_c), .caractere(car_c),
        .ocupado(ocup_c), .fim_mensagem(fim_c), .db_estado(est_c)
    );

    task automatic verifica(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obtido=%0h esperado=%0h", tag, obs, exp);
        end
    endtask

    task automatic verifica_txt(input string tag, input string obs,
                                input string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s obtido=\"%s\" esperado=\"%s\"", tag, obs, exp);
        end
    endtask

    function automatic void ler(input int sel, output logic p,
                                output logic [7:0] c, output logic f,
                                output logic o, output logic [2:0] e);
        case (sel)
            0: begin p = part_a; c = car_a; f = fim_a; o = ocup_a; e = est_a; end
            1: begin p = part_b; c = car_b; f = fim_b; o = ocup_b; e = est_b; end
            default: begin p = part_c; c = car_c; f = fim_c; o = ocup_c; e = est_c; end
        endcase
    endfunction

    task automatic set_pronto(input int sel, input logic v);
        case (sel)
            0: pronto_a = v;
            1: pronto_b = v;
            default: pronto_c = v;
        endcase
    endtask

    // Runs from a negedge; returns at the negedge where fim_mensagem is seen,
    // or where the abort_at-th character is two cycles into ESPERA.
    task automatic coletar(input int sel, input int abort_at, input bit perturbar,
                           output string s, output int nfim, output logic ocup_fim,
                           output int instavel, output bit estouro);
        int cnt = -1;
        int nch = 0;
        logic [7:0] atual = 8'h00;
        logic p, f, o;
        logic [7:0] c;
        logic [2:0] e;
        s = "";
        nfim = 0;
        ocup_fim = 1'b1;
        instavel = 0;
        estouro = 1'b1;
        for (int ciclo = 0; ciclo < 3000; ciclo++) begin
            ler(sel, p, c, f, o, e);
            if (f) begin
                nfim++;
                ocup_fim = o;
                estouro = 1'b0;
                break;
            end
            if (perturbar) begin
                ini_a = (nch == 3 && cnt == 5);
                if (nch == 3 && cnt == 5) dados_a = 36'h555_444_333;
            end
            if (p) begin
                nch++;
                atual = c;
                s = $sformatf("%s%c", s, c);
                cnt = 10;
            end else if (cnt > 0) begin
                cnt--;
                if (c !== atual) instavel++;
            end
            set_pronto(sel, cnt == 0);
            if (cnt == 0) cnt = -1;
            if (abort_at != 0 && nch == abort_at && cnt == 8) begin
                estouro = 1'b0;
                return;
            end
            @(negedge clock);
        end
        set_pronto(sel, 1'b0);
    endtask

    string s;
    int    nfim, instavel, extra_fim, extra_ocup;
    logic  ocup_fim;
    bit    estouro;

    initial begin
        reset = 1'b1;
        ini_a = 0; pronto_a = 0; dados_a = {12'hABC, 12'h0FF, 12'h1A3};
        ini_b = 0; pronto_b = 0; dados_b = 10'h3FF;
        ini_c = 0; pronto_c = 0; dados_c = 5'h1F;
        repeat (3) @(negedge clock);
        verifica("rst_partida", part_a, 0);
        verifica("rst_caractere", car_a, 8'h00);
        verifica("rst_ocupado", ocup_a, 0);
        verifica("rst_fim", fim_a, 0);
        verifica("rst_estado", est_a, 0);
        reset = 1'b0;
        @(negedge clock);

        pronto_a = 1'b1;
        @(negedge clock);
        pronto_a = 1'b0;
        verifica("pronto_idle_estado", est_a, 0);
        verifica("pronto_idle_ocupado", ocup_a, 0);

        // message with pronto in CARREGA, iniciar and dados change mid-flight
        ini_a = 1'b1;
        @(negedge clock);
        ini_a = 1'b0;
        verifica("captura_estado", est_a, 1);
        verifica("captura_ocupado", ocup_a, 1);
        pronto_a = 1'b1;
        @(negedge clock);
        pronto_a = 1'b0;
        verifica("pronto_carrega_estado", est_a, 2);
        coletar(0, 0, 1'b1, s, nfim, ocup_fim, instavel, estouro);
        ini_a = 1'b0;
        verifica("m1_timeout", estouro, 0);
        verifica_txt("m1_texto", s, EXP_A);
        verifica("m1_fim", nfim, 1);
        verifica("m1_ocupado_no_fim", ocup_fim, 0);
        verifica("m1_estavel", instavel, 0);
        dados_a = {12'hABC, 12'h0FF, 12'h1A3};
        extra_fim = 0;
        extra_ocup = 0;
        repeat (40) begin
            @(negedge clock);
            if (fim_a) extra_fim++;
            if (ocup_a) extra_ocup++;
        end
        verifica("m1_sem_segunda_fim", extra_fim, 0);
        verifica("m1_sem_segunda_ocup", extra_ocup, 0);

        // reset during ESPERA of the 5th character
        ini_a = 1'b1;
        @(negedge clock);
        ini_a = 1'b0;
        coletar(0, 5, 1'b0, s, nfim, ocup_fim, instavel, estouro);
        verifica("abort_alcancado", estouro, 0);
        verifica("abort_em_espera", est_a, 3);
        verifica_txt("abort_prefixo", s, "1A3,0");
        reset = 1'b1;
        #1;
        verifica("abort_partida", part_a, 0);
        verifica("abort_caractere", car_a, 8'h00);
        verifica("abort_ocupado", ocup_a, 0);
        verifica("abort_fim", fim_a, 0);
        verifica("abort_estado", est_a, 0);
        @(negedge clock);
        reset = 1'b0;
        pronto_a = 1'b0;
        @(negedge clock);
        ini_a = 1'b1;
        @(negedge clock);
        ini_a = 1'b0;
        coletar(0, 0, 1'b0, s, nfim, ocup_fim, instavel, estouro);
        verifica("m2_timeout", estouro, 0);
        verifica_txt("m2_texto", s, EXP_A);
        verifica("m2_fim", nfim, 1);

        // iniciar held high: next message starts right after FIM
        @(negedge clock);
        ini_a = 1'b1;
        @(negedge clock);
        coletar(0, 0, 1'b0, s, nfim, ocup_fim, instavel, estouro);
        verifica("b2b_timeout", estouro, 0);
        verifica_txt("b2b_texto1", s, EXP_A);
        verifica("b2b_ocupado_fim", ocup_fim, 0);
        @(negedge clock);
        verifica("b2b_idle", est_a, 0);
        @(negedge clock);
        verifica("b2b_recaptura", est_a, 1);
        verifica("b2b_ocupado", ocup_a, 1);
        ini_a = 1'b0;
        coletar(0, 0, 1'b0, s, nfim, ocup_fim, instavel, estouro);
        verifica("b2b_timeout2", estouro, 0);
        verifica_txt("b2b_texto2", s, EXP_A);

        // single channel, W=10
        ini_b = 1'b1;
        @(negedge clock);
        ini_b = 1'b0;
        coletar(1, 0, 1'b0, s, nfim, ocup_fim, instavel, estouro);
        verifica("w10_timeout", estouro, 0);
        verifica_txt("w10_texto", s, EXP_B);
        verifica("w10_estavel", instavel, 0);

        // single channel, W=5
        ini_c = 1'b1;
        @(negedge clock);
        ini_c = 1'b0;
        coletar(2, 0, 1'b0, s, nfim, ocup_fim, instavel, estouro);
        verifica("w5_timeout", estouro, 0);
        verifica_txt("w5_texto", s, EXP_C);
        verifica("w5_ocupado_fim", ocup_fim, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/telemetria_ascii_n.md
Name: telemetria_ascii_n

Overview:
Parametrised successor to the fixed 3-digit ASCII sender in the tank datapath. On a start pulse it snapshots N_CH measurement words of W bits each. It emits them as correct hexadecimal ASCII text (0-9, A-F), with a separator between channels and a terminator at the end. Characters go one at a time to tx_serial_8N1 through its partida/pronto handshake. It replaces the contador_m + mux_4x1_n + "+0x30" path and removes the old bug where nibbles above 9 produced ':'..'?'.

Parameters:
N_CH, 3, number of channels in the message (1..16)
W, 12, bits per channel (1..32); ND = ceil(W/4) hex digits per channel, upper nibble zero-padded
SEP, 8'h2C, separator character placed between channels (',')
TERM, 8'h23, terminator character ('#')

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
iniciar  in  1  start request; sampled only in IDLE
dados  in  N_CH*W  channel k occupies dados[k*W +: W]
pronto_tx  in  1  one-cycle pulse from tx_serial_8N1 when the current character has finished
partida_tx  out  1  one-cycle start pulse to tx_serial_8N1
caractere  out  8  ASCII character; stable from the partida_tx cycle until pronto_tx
ocupado  out  1  high from capture until message end
fim_mensagem  out  1  one-cycle pulse after the last character completes
db_estado  out  3  FSM state encoding, for debug

Behaviour:
- Reset values: partida_tx=0, caractere=8'h00, ocupado=0, fim_mensagem=0, FSM=IDLE, all counters 0. Reset mid-message aborts immediately; no partial-state resume.
- FSM states: IDLE, CARREGA, ENVIA, ESPERA, PROXIMO, FIM.
- IDLE: on a clock edge with iniciar=1, capture dados into a snapshot register, clear the channel/digit counters, set ocupado=1, go to CARREGA.
  - Later changes on dados do not affect the message in flight.
- CARREGA: register caractere from the current position, then go to ENVIA.
- ENVIA: partida_tx=1 for exactly this cycle, then go to ESPERA.
- ESPERA: hold caractere stable and wait for pronto_tx=1.
  - On pronto_tx: go to PROXIMO if more characters remain, otherwise to FIM.
  - pronto_tx outside ESPERA is ignored.
- PROXIMO: advance the position counter, then go to CARREGA. This gives 3 cycles from pronto_tx to the next partida_tx.
- FIM: fim_mensagem=1 and ocupado=0 in this cycle, then go to IDLE. A new iniciar is accepted from the following cycle.
- Character order per message:
  - ch0 digits MSB-nibble first, SEP, ch1 digits, …, SEP, ch(N_CH-1) digits, TERM.
  - Length L = N_CH*ND + (N_CH-1) + 1.
  - N_CH=1 produces no separator.
- Nibble mapping: 0..9 -> 8'h30..8'h39, 10..15 -> 8'h41..8'h46.
- iniciar while ocupado=1 is ignored (not queued).
- Counters: digit counter wraps ND-1 -> 0 and then selects the separator slot; channel counter increments after each separator. No counter overflows for the legal parameter ranges.
- db_estado encoding: IDLE=0, CARREGA=1, ENVIA=2, ESPERA=3, PROXIMO=4, FIM=5.

Optional Feature:
Macro TELEMETRIA_CHECKSUM_EN.
- Defined: between the last channel's digits and TERM, the block inserts '*' (8'h2A) followed by two uppercase hex digits. These digits are the 8-bit XOR of every character sent before '*', including separators.
  - A running XOR register is cleared at capture and updated in PROXIMO.
  - L increases by 3.
- Undefined: no checksum logic, no '*', and L as given above.

Decomposition:
- Package telemetria_pkg holds:
  - ASCII constants (ASC_ZERO, ASC_A, ASC_ASTERISCO, default SEP and TERM);
  - the FSM state encoding;
  - function nibble_para_ascii(4-bit) -> 8-bit.
- Natural sub-module: seletor_caractere, combinational. It takes the snapshot, channel index, digit index and slot type, and returns the 8-bit character. The FSM and counters stay in the top module.

Test Plan:
- N_CH=3, W=12, dados ch0=12'h1A3 ch1=12'h0FF ch2=12'hABC, bench replies with pronto_tx 10 cycles after each partida_tx:
  - macro undefined -> stream "1A3,0FF,ABC#" (12 chars);
  - then fim_mensagem pulses once and ocupado falls in the same cycle.
- Same stimulus with TELEMETRIA_CHECKSUM_EN defined -> "1A3,0FF,ABC*33#" (XOR = 8'h33).
- W=10, N_CH=1, dados=10'h3FF -> "3FF#"; W=5, dados=5'h1F -> "1F#". Checks padding and that no separator is emitted.
- iniciar pulsed again mid-message, and dados changed after capture -> output unchanged, no second message.
- reset asserted during ESPERA of the 5th character -> all outputs 0 in the same cycle. Next iniciar then starts a full message from ch0.
- pronto_tx pulsed while in IDLE/CARREGA -> ignored. Back-to-back: iniciar held high continuously -> new message starts the cycle after FIM.
